// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encoding shared by the operator unit, its interface and its users
package alu_pipe_pkg;
   localparam int OP_W    = 4;
   localparam int NUM_OPS = 14;
   typedef logic [OP_W-1:0] op_t;
   localparam op_t OP_ADD  = 4'd0;
   localparam op_t OP_SUB  = 4'd1;
   localparam op_t OP_SHL  = 4'd2;
   localparam op_t OP_SHR  = 4'd3;
   localparam op_t OP_LT   = 4'd4;
   localparam op_t OP_EQ   = 4'd5;
   localparam op_t OP_AND  = 4'd6;
   localparam op_t OP_OR   = 4'd7;
   localparam op_t OP_XOR  = 4'd8;
   localparam op_t OP_RAND = 4'd9;
   localparam op_t OP_RXOR = 4'd10;
   localparam op_t OP_LAND = 4'd11;
   localparam op_t OP_CAT  = 4'd12;
   localparam op_t OP_COND = 4'd13;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand-side and result-side valid/ready bundle of the operator unit
interface alu_pipe_if import alu_pipe_pkg::*; #(parameter int WIDTH = 4);
   logic             in_valid, in_ready, out_valid, out_ready;
   op_t              op;
   logic [WIDTH-1:0] a, b, c, d, result;
   logic             flag, carry, zero, err;
   modport master (output in_valid, op, a, b, c, d, out_ready,
                   input  in_ready, out_valid, result, flag, carry, zero, err);
   modport slave  (input  in_valid, op, a, b, c, d, out_ready,
                   output in_ready, out_valid, result, flag, carry, zero, err);
endinterface

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational evaluator for one opcode on WIDTH-bit unsigned operands
module alu_pipe_core import alu_pipe_pkg::*; #(parameter int WIDTH = 4) (
   input  op_t              op,
   input  logic [WIDTH-1:0] a, b, c, d,
   output logic [WIDTH-1:0] result,
   output logic             flag, carry, err
);
   localparam int H = WIDTH / 2;
   always_comb begin
      result = '0;
      flag   = 1'b0;
      carry  = 1'b0;
      err    = 1'b0;
      case (op)
         OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB:  begin result = a - b; carry = a < b; end
         OP_SHL:  result = a << b;
         OP_SHR:  result = a >> b;
         OP_LT:   flag = a < b;
         OP_EQ:   flag = a == b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_RAND: flag = &a;
         OP_RXOR: flag = ^a;
         OP_LAND: flag = (|a) && (|b);
         OP_CAT:  result = {a[H-1:0], b[H-1:0]};
         OP_COND: result = (a > b) ? c : d;
         default: err = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipeline around alu_pipe_core, one operation per cycle
module alu_pipe import alu_pipe_pkg::*; #(parameter int WIDTH = 4) (
   input logic     clk,
   input logic     rst_n,
   alu_pipe_if.slave io
);
   logic             s1_valid, s2_valid, adv1, adv2;
   op_t              s1_op;
   logic [WIDTH-1:0] s1_a, s1_b, s1_c, s1_d, c_result;
   logic             c_flag, c_carry, c_err;
   assign adv2         = !s2_valid || io.out_ready;
   assign adv1         = !s1_valid || adv2;
   assign io.in_ready  = adv1;
   assign io.out_valid = s2_valid;
   alu_pipe_core #(.WIDTH(WIDTH)) u_core (
      .op(s1_op), .a(s1_a), .b(s1_b), .c(s1_c), .d(s1_d),
      .result(c_result), .flag(c_flag), .carry(c_carry), .err(c_err)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_c     <= '0;
         s1_d     <= '0;
      end else if (adv1) begin
         s1_valid <= io.in_valid;
         if (io.in_valid) begin
            s1_op <= io.op;
            s1_a  <= io.a;
            s1_b  <= io.b;
            s1_c  <= io.c;
            s1_d  <= io.d;
         end
      end
   end
   // flag ops leave result at 0, so zero reduces to "no result bits and no flag"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         io.result <= '0;
         io.flag   <= 1'b0;
         io.carry  <= 1'b0;
         io.zero   <= 1'b0;
         io.err    <= 1'b0;
      end else if (adv2) begin
         s2_valid  <= s1_valid;
         io.result <= c_result;
         io.flag   <= c_flag;
         io.carry  <= c_carry;
         io.zero   <= ~|c_result & ~c_flag;
         io.err    <= c_err;
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed WIDTH=4 checks plus randomized WIDTH=8 traffic against a reference model
module tb_alu_pipe;
   import alu_pipe_pkg::*;
   localparam int N_RAND = 10000;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   always #5 clk = ~clk;
   alu_pipe_if #(.WIDTH(4)) i4 ();
   alu_pipe_if #(.WIDTH(8)) i8 ();
   alu_pipe #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .io(i4));
   alu_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .io(i8));
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // packed view {err,zero,carry,flag,result[7:0]}
   function automatic logic [31:0] pk4();
      return {20'b0, i4.err, i4.zero, i4.carry, i4.flag, 4'b0, i4.result};
   endfunction
   function automatic logic [31:0] pk8();
      return {20'b0, i8.err, i8.zero, i8.carry, i8.flag, i8.result};
   endfunction
   function automatic logic [31:0] model(int w, int op, int a, int b, int c, int d);
      int m = 1 << w;
      int h = 1 << (w / 2);
      int r = 0;
      bit f = 0, cy = 0, e = 0, isf, z;
      case (op)
         0:  begin r = (a + b) % m; cy = (a + b) >= m; end
         1:  begin r = (a - b + m) % m; cy = a < b; end
         2:  r = (b >= w) ? 0 : (a * (1 << b)) % m;
         3:  r = (b >= w) ? 0 : a / (1 << b);
         4:  f = a < b;
         5:  f = a == b;
         6:  r = a & b;
         7:  r = a | b;
         8:  r = a ^ b;
         9:  f = a == m - 1;
         10: f = ($countones(a) % 2) == 1;
         11: f = (a != 0) && (b != 0);
         12: r = (a % h) * h + (b % h);
         13: r = (a > b) ? c : d;
         default: e = 1;
      endcase
      isf = (op == 4) || (op == 5) || (op == 9) || (op == 10) || (op == 11);
      z = isf ? !f : (r == 0);
      return {20'b0, e, z, cy, f, r[7:0]};
   endfunction
   task automatic drive4(logic vld, op_t op, logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
      i4.in_valid = vld;
      i4.op = op;
      i4.a = a;
      i4.b = b;
      i4.c = c;
      i4.d = d;
   endtask
   task automatic lat4(string tag, op_t op, logic [3:0] a, logic [3:0] b, logic [31:0] exp);
      @(posedge clk); #1 drive4(1, op, a, b, 4'h0, 4'h0);
      @(posedge clk); #1 i4.in_valid = 0;
      @(negedge clk) check({tag, "_early"}, i4.out_valid, 0);
      @(negedge clk) check({tag, "_valid"}, i4.out_valid, 1);
      check(tag, pk4(), exp);
   endtask
   initial begin
      logic [31:0] exp_s[4];
      op_t         op_s[4];
      logic [3:0]  a_s[4], b_s[4], c_s[4], d_s[4];
      i4.out_ready = 1;
      drive4(0, OP_ADD, 0, 0, 0, 0);
      i8.in_valid = 0; i8.out_ready = 1; i8.op = OP_ADD;
      i8.a = 0; i8.b = 0; i8.c = 0; i8.d = 0;
      #2;
      check("rst_out_valid", i4.out_valid, 0);
      check("rst_outputs", pk4(), 0);
      check("rst_in_ready", i4.in_ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1;
      lat4("add", OP_ADD, 4'b1100, 4'b0110, 32'h202);
      op_s = '{OP_SUB, OP_COND, OP_EQ, OP_RAND};
      a_s = '{4'b1010, 4'b1100, 4'b1100, 4'b1111};
      b_s = '{4'b0011, 4'b0110, 4'b1100, 4'b0000};
      c_s = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
      d_s = '{4'b0000, 4'b1100, 4'b0000, 4'b0000};
      exp_s = '{32'h007, 32'h002, 32'h100, 32'h100};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i < 4) drive4(1, op_s[i], a_s[i], b_s[i], c_s[i], d_s[i]);
         else i4.in_valid = 0;
         @(negedge clk);
         if (i >= 2) begin
            check($sformatf("stream%0d_valid", i - 2), i4.out_valid, 1);
            check($sformatf("stream%0d", i - 2), pk4(), exp_s[i - 2]);
         end
      end
      @(negedge clk) check("stream_done", i4.out_valid, 0);
      @(posedge clk); #1 i4.out_ready = 0; drive4(1, OP_SHL, 4'b0011, 4'b0100, 0, 0);
      @(posedge clk); #1 drive4(1, 4'd15, 4'b1010, 4'b0101, 0, 0);
      @(posedge clk); #1 drive4(1, OP_CAT, 4'b1010, 4'b0111, 0, 0);
      @(negedge clk);
      check("bp_ready0", i4.in_ready, 0);
      check("bp_out0", {15'b0, i4.out_valid, pk4()[15:0]}, 32'h10400);
      @(posedge clk); @(negedge clk);
      check("bp_ready1", i4.in_ready, 0);
      check("bp_hold", {15'b0, i4.out_valid, pk4()[15:0]}, 32'h10400);
      @(posedge clk); #1 i4.out_ready = 1;
      @(negedge clk);
      check("bp_release_ready", i4.in_ready, 1);
      check("bp_shl", pk4(), 32'h400);
      @(posedge clk); #1 i4.in_valid = 0;
      @(negedge clk) check("bp_illegal", {15'b0, i4.out_valid, pk4()[15:0]}, 32'h10C00);
      @(negedge clk) check("bp_cat", {15'b0, i4.out_valid, pk4()[15:0]}, 32'h1000B);
      @(negedge clk) check("bp_drained", i4.out_valid, 0);
      @(posedge clk); #1 i4.out_ready = 0; drive4(1, OP_OR, 4'b0001, 4'b0010, 0, 0);
      @(posedge clk); #1 drive4(1, OP_XOR, 4'b1111, 4'b0001, 0, 0);
      @(posedge clk); #1 i4.in_valid = 0;
      @(negedge clk) check("full_before_reset", i4.out_valid, 1);
      #2 rst_n = 0;
      #1;
      check("async_rst_valid", i4.out_valid, 0);
      check("async_rst_outputs", pk4(), 0);
      check("async_rst_ready", i4.in_ready, 1);
      @(negedge clk); rst_n = 1; i4.out_ready = 1;
      lat4("post_rst_add", OP_ADD, 4'b0101, 4'b0011, 32'h008);
      @(negedge clk) check("post_rst_single", i4.out_valid, 0);
      run_rand();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
   task automatic run_rand();
      logic [31:0] q[$];
      logic [31:0] held = 0;
      bit          pend = 0, stall = 0;
      int          n_acc = 0, n_out = 0, cyc = 0;
      @(posedge clk); #1 i8.in_valid = 1; i8.op = OP_ADD; i8.a = 8'hFF; i8.b = 8'h01;
      @(posedge clk); #1 i8.in_valid = 0;
      @(negedge clk) check("w8_early", i8.out_valid, 0);
      @(negedge clk) check("w8_add_ff", {15'b0, i8.out_valid, pk8()[15:0]}, 32'h10600);
      while ((n_acc < N_RAND || q.size() > 0) && cyc < 50000) begin
         @(posedge clk); #1;
         cyc++;
         if (!pend) begin
            i8.in_valid = (n_acc < N_RAND) && ($urandom % 5 != 0);
            i8.op = 4'($urandom_range(0, 15));
            i8.a = 8'($urandom);
            i8.b = ($urandom % 4 == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            i8.c = 8'($urandom);
            i8.d = 8'($urandom);
         end
         i8.out_ready = ($urandom % 4) != 0;
         @(negedge clk);
         check("rnd_ready", i8.in_ready, (q.size() < 2) || i8.out_ready);
         if (stall) check("rnd_hold", {15'b0, i8.out_valid, pk8()[15:0]}, {15'b0, 1'b1, held[15:0]});
         if (i8.out_valid && i8.out_ready) begin
            if (q.size() == 0) check("rnd_spurious", 1, 0);
            else check("rnd_result", pk8(), q.pop_front());
            n_out++;
         end
         stall = i8.out_valid && !i8.out_ready;
         held = pk8();
         if (i8.in_valid && i8.in_ready) begin
            q.push_back(model(8, i8.op, i8.a, i8.b, i8.c, i8.d));
            n_acc++;
            pend = 0;
         end else pend = i8.in_valid;
      end
      i8.in_valid = 0;
      check("rnd_count", n_out, N_RAND);
      check("rnd_drained", q.size(), 0);
   endtask
endmodule
